ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
Single-transfer AHB-Lite master that turns a simple valid/ready command stream into pipelined NONSEQ transfers. It is the initiator side for the team's AHB-Lite slave memory and is used in testbenches and as a bridge from local logic onto the bus. The next command's address phase overlaps the current data phase. The master implements the two-cycle ERROR cancel rule and returns one response per command, in order.

Parameters:
HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, privileged, data access).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  byte address
cmd_size  in  3  HSIZE encoding; legal values 0..2 only
cmd_wdata  in  32  write data, captured with the command
rsp_valid  out  1  one-cycle pulse per completed command
rsp_write  out  1  direction of the completed command
rsp_rdata  out  32  read data; 0 for writes
rsp_error  out  1  slave returned ERROR
HADDR  out  32
HWRITE  out  1
HSIZE  out  3
HBURST  out  3  fixed 3'b000 (SINGLE)
HPROT  out  4  = HPROT_VAL
HTRANS  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
HMASTLOCK  out  1  fixed 0
HWDATA  out  32
HREADY  in  1  from interconnect/slave mux
HRESP  in  1  OKAY=0, ERROR=1
HRDATA  in  32

Behaviour:
- Clock and reset: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0, all internal slots empty, cancel flag clear.
- Reset mid-transfer drops all in-flight commands; no response is generated for them.
- Internal state:
  - Address slot: a_valid, addr, write, size, wdata.
  - Data slot: d_valid, write, wdata.
  - cancel flag.
- Bus outputs are registered from the address slot: HTRANS = NONSEQ when a_valid && !cancel, else IDLE. HADDR, HWRITE and HSIZE come from the slot. HWDATA = data-slot wdata, held stable while HREADY=0.
- cmd_ready is combinational: (!a_valid || HREADY) && !cancel && !(HREADY==0 && HRESP==1).
- At a posedge with HREADY=1 and cancel=0:
  - The data slot is replaced by the address slot.
  - The address slot loads the accepted command, or empties.
  - If the old data slot was valid, it completes (see responses).
- At a posedge with HREADY=0:
  - Both slots hold.
  - If HRESP=1 (first ERROR cycle), set cancel. HTRANS goes IDLE during the second ERROR cycle.
- At a posedge with HREADY=1 and cancel=1 (second ERROR cycle):
  - The data slot completes with error and then empties.
  - The address slot is retained and cancel clears.
  - The retained command is re-driven as NONSEQ on the next cycle; it is not lost or duplicated.
- Responses are registered and appear one cycle after the completing edge:
  - rsp_valid pulses for one cycle.
  - rsp_rdata = HRDATA sampled at completion for reads, 0 for writes.
  - rsp_error = HRESP at completion.
  - rsp_write = write bit of the completed command.
  - There is no backpressure on responses.
- Ordering: responses are in command order. At most 2 commands are in flight. Throughput is 1 command per cycle under zero-wait OKAY.
- Wait states: any number of HREADY=0 cycles are tolerated. Address and control stay stable throughout.
- Illegal input: cmd_size > 2 or an address misaligned to its size is illegal. The block does not check for it; the bench flags it with an assertion.

Test Plan:
- Reset: hold HRESETn=0, then release → HTRANS=00, rsp_valid=0, cmd_ready=1.
- Single write: write 0x0000_0010, size 2, data 0xDEADBEEF, HREADY=1 → NONSEQ on cycle 1, HWDATA=0xDEADBEEF on cycle 2, rsp_valid with rsp_error=0 on cycle 3.
- Back-to-back reads: reads at 0x0, 0x4, 0x8, zero wait states; slave returns 0x11, 0x22, 0x33 → HADDR advances every cycle, three consecutive rsp pulses with rsp_rdata 0x11, 0x22, 0x33.
- Wait states: read at 0x20 with HREADY low for 3 cycles → HADDR, HSIZE and the pending next command stay stable; exactly one response; cmd_ready=0 while the slot is full.
- ERROR with pipelined command: write to 0x400 draws the ERROR pattern (HREADY 0/1, HRESP 1/1) while a read at 0x8 is queued → HTRANS=IDLE in the second ERROR cycle; rsp_error=1 for the write; the read at 0x8 is reissued and completes OKAY.
- Reset mid-operation: assert HRESETn during a wait-stated transfer → outputs go to reset values immediately; no rsp_valid for the dropped command.

Source files
------------

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_master
//  Brief    : Single-transfer AHB-Lite master. Converts a valid/ready command
//             stream into pipelined NONSEQ transfers, handles the two-cycle
//             ERROR cancel and returns one in-order response per command.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // Command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    // Response stream (no backpressure)
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    // AHB-Lite master interface
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [1:0]  HTRANS,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

    // Address slot: command currently driven in its address phase
    logic        r_a_valid;
    logic [31:0] r_a_addr;
    logic        r_a_write;
    logic [2:0]  r_a_size;
    logic [31:0] r_a_wdata;
    // Data slot: command currently in its data phase
    logic        r_d_valid;
    logic        r_d_write;
    logic [31:0] r_d_wdata;
    // Set after the first ERROR cycle; suppresses the pending address phase
    logic        r_cancel;
    // Registered response
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;

    logic w_err_first;
    logic w_err_second;
    logic w_advance;
    logic w_accept;
    logic w_complete;

    // First ERROR cycle: slave stretches with HRESP high
    assign w_err_first  = !HREADY && HRESP;
    // Second ERROR cycle: transfer ends while the cancel flag is set
    assign w_err_second = HREADY && r_cancel;
    // Normal pipeline step
    assign w_advance    = HREADY && !r_cancel;
    // The data-phase command finishes on any ready edge
    assign w_complete   = HREADY && r_d_valid;

    assign cmd_ready = (!r_a_valid || HREADY) && !r_cancel && !w_err_first;
    assign w_accept  = cmd_valid && cmd_ready;

    // Pipeline slots: shift address->data on ready edges, hold during waits
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a_valid <= 1'b0;
            r_a_addr  <= 32'd0;
            r_a_write <= 1'b0;
            r_a_size  <= 3'd0;
            r_a_wdata <= 32'd0;
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_d_wdata <= 32'd0;
        end else if (w_advance) begin
            r_d_valid <= r_a_valid;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_wdata;
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_a_addr  <= cmd_addr;
                r_a_write <= cmd_write;
                r_a_size  <= cmd_size;
                r_a_wdata <= cmd_wdata;
            end
        end else if (w_err_second) begin
            // Errored transfer leaves; the cancelled command stays for reissue
            r_d_valid <= 1'b0;
        end else if (w_accept) begin
            // Wait state with an empty address slot: take the command now
            r_a_valid <= 1'b1;
            r_a_addr  <= cmd_addr;
            r_a_write <= cmd_write;
            r_a_size  <= cmd_size;
            r_a_wdata <= cmd_wdata;
        end
    end

    // Cancel flag: raised by the first ERROR cycle, cleared by the second
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cancel <= 1'b0;
        end else if (w_err_first) begin
            r_cancel <= 1'b1;
        end else if (w_err_second) begin
            r_cancel <= 1'b0;
        end
    end

    // Response register: one-cycle pulse carrying the completed transfer result
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= w_complete;
            if (w_complete) begin
                r_rsp_write <= r_d_write;
                r_rsp_rdata <= r_d_write ? 32'd0 : HRDATA;
                r_rsp_error <= HRESP;
            end
        end
    end

    assign HTRANS    = (r_a_valid && !r_cancel) ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
    assign HADDR     = r_a_addr;
    assign HWRITE    = r_a_write;
    assign HSIZE     = r_a_size;
    assign HWDATA    = r_d_wdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_master
//  Brief    : Self-checking bench for ahb_lite_master with an AHB slave model,
//             a word memory and an in-order reference of expected responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_master;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } cmd_t;

    typedef struct packed {
        logic        w;
        logic [31:0] rd;
        logic        e;
    } rsp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_rsp = 0;
    int   base;
    cmd_t pend_q[$];
    cmd_t bus_q[$];
    rsp_t exp_q[$];
    int   wq[$];
    logic [31:0] refmem [64];
    logic [31:0] smem [64];
    bit   rnd_mode;
    // slave data-phase state
    bit          dp_active;
    bit          dp_write;
    bit          dp_err;
    int          dp_wait;
    int          dp_stage;
    int          dp_idx;
    logic [31:0] dp_wdata;
    // previous-cycle bus snapshot
    bit          p_valid;
    logic [1:0]  p_htrans;
    logic [31:0] p_haddr;
    logic [2:0]  p_hsize;
    logic        p_hwrite;
    logic        p_hready;
    logic        p_hresp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: each accepted command yields one response in order.
    // Addresses with bit 10 set are answered with ERROR by the slave.
    task automatic model_accept(input cmd_t c);
        rsp_t r;
        int   idx;
        bit   legal;
        idx   = int'(c.a[7:2]);
        legal = (c.s <= 3'd2) && ((c.a & ((32'd1 << c.s) - 32'd1)) == 32'd0);
        chk("cmd_legal", 32'(legal), 32'd1);
        r.w  = c.w;
        r.e  = c.a[10];
        r.rd = (c.w || c.a[10]) ? 32'd0 : refmem[idx];
        if (c.w && !c.a[10]) refmem[idx] = c.d;
        exp_q.push_back(r);
        bus_q.push_back(c);
    endtask

    // One bus cycle: check outputs, play the slave, offer a command
    task automatic cycle();
        cmd_t c;
        rsp_t r;
        @(negedge HCLK);
        if (rsp_valid) begin
            n_rsp++;
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(r.w));
                chk("rsp_rdata", rsp_rdata, r.rd);
                chk("rsp_error", 32'(rsp_error), 32'(r.e));
            end
        end
        chk("htrans_legal", 32'(HTRANS == 2'b00 || HTRANS == 2'b10), 32'd1);
        if (p_valid && HRESETn && !p_hready && !p_hresp && p_htrans == 2'b10) begin
            chk("hold_htrans", 32'(HTRANS), 32'(p_htrans));
            chk("hold_haddr", HADDR, p_haddr);
            chk("hold_hsize", 32'(HSIZE), 32'(p_hsize));
            chk("hold_hwrite", 32'(HWRITE), 32'(p_hwrite));
        end
        if (dp_active && dp_write) chk("hwdata", HWDATA, dp_wdata);
        // slave response for this cycle
        HRDATA = $urandom;
        if (!dp_active) begin
            HREADY = 1'b1; HRESP = 1'b0;
        end else if (dp_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
        end else if (dp_err && dp_stage == 0) begin
            HREADY = 1'b0; HRESP = 1'b1; dp_stage = 1;
        end else if (dp_err) begin
            HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'd0; dp_active = 1'b0;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (dp_write) smem[dp_idx] = dp_wdata;
            else HRDATA = smem[dp_idx];
            dp_active = 1'b0;
        end
        // address phase sampled at the coming edge
        if (HREADY && HRESETn && HTRANS == 2'b10) begin
            chk("addr_phase_expected", 32'(bus_q.size() > 0), 32'd1);
            if (bus_q.size() > 0) begin
                c = bus_q.pop_front();
                chk("haddr", HADDR, c.a);
                chk("hwrite", 32'(HWRITE), 32'(c.w));
                chk("hsize", 32'(HSIZE), 32'(c.s));
                chk("hburst", 32'(HBURST), 32'd0);
                chk("hprot", 32'(HPROT), 32'h3);
                chk("hmastlock", 32'(HMASTLOCK), 32'd0);
                dp_active = 1'b1;
                dp_write  = c.w;
                dp_wdata  = c.d;
                dp_idx    = int'(c.a[7:2]);
                dp_err    = c.a[10];
                dp_stage  = 0;
                if (wq.size() > 0) dp_wait = wq.pop_front();
                else dp_wait = rnd_mode ? int'($urandom_range(0, 2)) : 0;
            end
        end
        p_valid = HRESETn; p_htrans = HTRANS; p_haddr = HADDR; p_hsize = HSIZE;
        p_hwrite = HWRITE; p_hready = HREADY; p_hresp = HRESP;
        // command offer
        if (pend_q.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
            c = pend_q[0];
            cmd_valid = 1'b1; cmd_write = c.w; cmd_addr = c.a;
            cmd_size = c.s; cmd_wdata = c.d;
        end else begin
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
            cmd_size = 3'($urandom); cmd_wdata = $urandom;
        end
        #1;
        if (cmd_valid && cmd_ready && HRESETn) begin
            c = pend_q.pop_front();
            model_accept(c);
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && k < limit) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(exp_q.size() + pend_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_size = 3'd0; cmd_wdata = 32'd0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        rnd_mode = 1'b0; dp_active = 1'b0; p_valid = 1'b0; dp_wait = 0; dp_stage = 0;
        dp_idx = 0; dp_write = 1'b0; dp_err = 1'b0; dp_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            refmem[i] = $urandom;
            smem[i]   = refmem[i];
        end
        refmem[0] = 32'h11; refmem[1] = 32'h22; refmem[2] = 32'h33;
        smem[0]   = 32'h11; smem[1]   = 32'h22; smem[2]   = 32'h33;

        // Reset
        repeat (3) cycle();
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        HRESETn = 1'b1;
        cycle();
        chk("rel_htrans", 32'(HTRANS), 32'd0);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write
        pend_q.push_back('{1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF});
        cycle();
        chk("wr_accepted", 32'(pend_q.size()), 32'd0);
        cycle();
        chk("wr_htrans", 32'(HTRANS), 32'h2);
        chk("wr_haddr", HADDR, 32'h10);
        chk("wr_hwrite", 32'(HWRITE), 32'd1);
        cycle();
        chk("wr_hwdata", HWDATA, 32'hDEADBEEF);
        chk("wr_rsp_early", 32'(rsp_valid), 32'd0);
        cycle();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_error", 32'(rsp_error), 32'd0);
        chk("wr_rsp_write", 32'(rsp_write), 32'd1);

        // Back-to-back reads
        pend_q.push_back('{1'b0, 32'h0, 3'd2, 32'h0});
        pend_q.push_back('{1'b0, 32'h4, 3'd2, 32'h0});
        pend_q.push_back('{1'b0, 32'h8, 3'd2, 32'h0});
        cycle();
        cycle(); chk("b2b_haddr0", HADDR, 32'h0);
        cycle(); chk("b2b_haddr1", HADDR, 32'h4);
        cycle(); chk("b2b_haddr2", HADDR, 32'h8);
        chk("b2b_rsp0_v", 32'(rsp_valid), 32'd1); chk("b2b_rsp0_d", rsp_rdata, 32'h11);
        cycle(); chk("b2b_rsp1_v", 32'(rsp_valid), 32'd1); chk("b2b_rsp1_d", rsp_rdata, 32'h22);
        cycle(); chk("b2b_rsp2_v", 32'(rsp_valid), 32'd1); chk("b2b_rsp2_d", rsp_rdata, 32'h33);
        drain(50);

        // Wait states with a pending next command
        base = n_rsp;
        wq.push_back(3);
        pend_q.push_back('{1'b0, 32'h20, 3'd2, 32'h0});
        pend_q.push_back('{1'b0, 32'h24, 3'd1, 32'h0});
        cycle();
        cycle(); chk("ws_haddr", HADDR, 32'h20);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ws_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("ws_next_haddr", HADDR, 32'h24);
            chk("ws_next_hsize", 32'(HSIZE), 32'd1);
            chk("ws_next_htrans", 32'(HTRANS), 32'h2);
        end
        drain(50);
        repeat (2) cycle();
        chk("ws_rsp_count", 32'(n_rsp - base), 32'd2);

        // ERROR with a pipelined command
        base = n_rsp;
        pend_q.push_back('{1'b1, 32'h400, 3'd2, 32'hCAFEF00D});
        pend_q.push_back('{1'b0, 32'h8, 3'd2, 32'h0});
        cycle();
        cycle(); chk("err_haddr", HADDR, 32'h400);
        cycle(); chk("err1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("err1_htrans", 32'(HTRANS), 32'h2);
        cycle(); chk("err2_htrans", 32'(HTRANS), 32'h0);
        chk("err2_cmd_ready", 32'(cmd_ready), 32'd0);
        cycle(); chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_error", 32'(rsp_error), 32'd1);
        chk("reissue_htrans", 32'(HTRANS), 32'h2);
        chk("reissue_haddr", HADDR, 32'h8);
        cycle();
        cycle(); chk("reissue_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("reissue_rsp_error", 32'(rsp_error), 32'd0);
        chk("reissue_rsp_rdata", rsp_rdata, 32'h33);
        drain(50);
        repeat (2) cycle();
        chk("err_rsp_count", 32'(n_rsp - base), 32'd2);

        // Reset in the middle of a wait-stated transfer
        wq.push_back(6);
        pend_q.push_back('{1'b0, 32'h30, 3'd2, 32'h0});
        repeat (4) cycle();
        chk("mid_in_wait", 32'(HREADY), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("mid_htrans", 32'(HTRANS), 32'd0);
        chk("mid_haddr", HADDR, 32'd0);
        chk("mid_hwdata", HWDATA, 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete(); bus_q.delete(); pend_q.delete(); wq.delete();
        dp_active = 1'b0; p_valid = 1'b0;
        base = n_rsp;
        repeat (2) cycle();
        HRESETn = 1'b1;
        repeat (6) cycle();
        chk("mid_no_rsp", 32'(n_rsp - base), 32'd0);

        // Randomized traffic
        rnd_mode = 1'b1;
        base = n_rsp;
        for (int i = 0; i < 300; i++) begin
            cmd_t        c;
            logic [31:0] a;
            logic [2:0]  s;
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) a[10] = 1'b1;
            if (s == 3'd1) a[1] = 1'($urandom_range(0, 1));
            if (s == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
            c.w = 1'($urandom_range(0, 1));
            c.a = a;
            c.s = s;
            c.d = $urandom;
            pend_q.push_back(c);
        end
        drain(5000);
        repeat (3) cycle();
        chk("rnd_rsp_count", 32'(n_rsp - base), 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
